// File: rtl/countone_udiv_seq_32ns_16ns.sv
`default_nettype none
// ============================================================================
// Module  : countone_udiv_seq_32ns_16ns
// Brief   : Iterative restoring radix-2 unsigned divider, one quotient bit
//           per ce-enabled cycle, start/done handshake.
// Revision: 1.0
// ============================================================================
module countone_udiv_seq_32ns_16ns #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      ready,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DIVIDEND_WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [DIVIDEND_WIDTH-1:0] r_dvd;
  logic [DIVISOR_WIDTH-1:0]  r_dvs;
  logic [DIVISOR_WIDTH:0]    r_rem;
  logic [DIVIDEND_WIDTH-1:0] r_quotient;
  logic [DIVISOR_WIDTH-1:0]  r_remainder;
  logic                      r_dbz;

  logic [DIVISOR_WIDTH:0]    w_shift;
  logic [DIVISOR_WIDTH:0]    w_diff;
  logic                      w_ge;
  logic [DIVISOR_WIDTH:0]    w_rem_next;
  logic [DIVIDEND_WIDTH-1:0] w_dvd_next;

  // One restoring step; r_dvd doubles as the quotient shift register, so after
  // the last step it holds the full quotient. A zero divisor naturally yields
  // all-ones quotient and the low dividend bits as remainder.
  always_comb begin
    w_shift    = {r_rem[DIVISOR_WIDTH-1:0], r_dvd[DIVIDEND_WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dvs};
    w_ge       = (w_shift >= {1'b0, r_dvs});
    w_rem_next = w_ge ? w_diff : w_shift;
    w_dvd_next = {r_dvd[DIVIDEND_WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == c_cnt_last) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (ce) begin
      if (r_state == S_IDLE && start) begin
        r_dvd <= dividend;
        r_dvs <= divisor;
        r_rem <= '0;
        r_cnt <= c_cnt_load;
      end else if (r_state == S_CALC) begin
        r_dvd <= w_dvd_next;
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - c_cnt_last;
        // Results publish on the edge that enters FIN, so they are valid with done.
        if (r_cnt == c_cnt_last) begin
          r_quotient  <= w_dvd_next;
          r_remainder <= w_rem_next[DIVISOR_WIDTH-1:0];
          r_dbz       <= (r_dvs == '0);
        end
      end
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign done        = (r_state == S_FIN);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
